// File: rtl/dm_write_buffer.sv
// Posted-store write buffer between the MEM-stage lane controller and data memory.
// Stores drain in order to a multi-cycle port; loads merge pending bytes, newest wins.
module dm_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_wea,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wea,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // state | meaning
  // IDLE  | no memory transaction; pick a pending load, else drain the head entry
  // WR    | head entry write outstanding; popped on its ack
  // RD    | load read outstanding; merged word registered on its ack
  // RESP  | load retires (stall low), back to IDLE

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  state_t             state;
  logic [29:0]        ent_addr [DEPTH];
  logic [3:0]         ent_wea  [DEPTH];
  logic [31:0]        ent_data [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               is_store;
  logic               is_load;
  logic               full;
  logic               push;
  logic               pop;
  logic [3:0]         cover_wea;
  logic [31:0]        merged;
  logic [PTR_W-1:0]   idx;
  logic [1:0]         unused_addr_lsb;

  assign unused_addr_lsb = cpu_addr[1:0];

  assign is_store  = (cpu_wea != 4'b0000);
  assign is_load   = cpu_re && !is_store;
  assign full      = (count == CNT_W'(DEPTH));
  assign push      = is_store && !full;
  assign pop       = (state == WR) && mem_ack;
  // Gated by rstn so a reset pipeline never sees a stall from a held load.
  assign cpu_stall = rstn && ((is_store && full) || (is_load && (state != RESP)));

  // Walk valid entries oldest to newest so later stores overwrite earlier bytes.
  always_comb begin
    cover_wea = 4'b0000;
    merged    = (state == RD) ? mem_rdata : 32'h0;
    idx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (ent_addr[idx] == cpu_addr[31:2])) begin
        cover_wea = cover_wea | ent_wea[idx];
        for (int b = 0; b < 4; b++) begin
          if (ent_wea[idx][b]) merged[8*b +: 8] = ent_data[idx][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_wea[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (push) begin
        ent_addr[tail] <= cpu_addr[31:2];
        ent_wea[tail]  <= cpu_wea;
        ent_data[tail] <= cpu_wdata;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wea   <= 4'b0000;
      mem_wdata <= 32'h0;
      cpu_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (is_load) begin
            if (cover_wea == 4'b1111) begin
              cpu_rdata <= merged;
              state     <= RESP;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {cpu_addr[31:2], 2'b00};
              mem_wea  <= 4'b0000;
              state    <= RD;
            end
          end else if (count != '0) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {ent_addr[head], 2'b00};
            mem_wea   <= ent_wea[head];
            mem_wdata <= ent_data[head];
            state     <= WR;
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= IDLE;
          end
        end
        RD: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            cpu_rdata <= merged;
            state     <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
